// File: rtl/shift_add_mult_ctrl.sv
// -----------------------------------------------------------------------------
// shift_add_mult_ctrl
//   Sequential unsigned N x N shift-and-add multiplier. A single shared
//   full_adder_nbit performs one conditional add per cycle. The 2N-bit product
//   {ACC, Q} is returned through a valid/ready handshake.
//
//   Optional build macro: EARLY_TERM_EN
//     When defined, CALC finishes early once all unconsumed multiplier bits
//     are zero. The remaining shifts are collapsed into one barrel shift.
//     When undefined, latency is always exactly N cycles.
//
//   Parameters:
//     N            operand width (N >= 2), product is 2N bits
//
//   Ports:
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     start_valid  operands a/b valid
//     start_ready  block can accept operands (IDLE only)
//     a            multiplicand, sampled on accept
//     b            multiplier, sampled on accept
//     done_valid   product valid (DONE only)
//     done_ready   consumer accepts product
//     product      registered result {ACC, Q}, held until the next accept
//     busy         high in CALC or DONE
// -----------------------------------------------------------------------------

module full_adder_nbit #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o,
    output logic         overflow_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
    // Two's-complement overflow: operands agree in sign, sum does not.
    assign overflow_o = (a_i[N-1] == b_i[N-1]) && (sum_o[N-1] != a_i[N-1]);

endmodule

module shift_add_mult_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done_valid,
    input  logic           done_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     m_q, m_d;
    logic [2*N-1:0]   p_q, p_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [N-1:0]     acc;
    logic [N-1:0]     addend;
    logic [N-1:0]     sum;
    logic             cout;
    logic             adder_ovf_unused;
    logic [2*N-1:0]   p_step;

    assign acc    = p_q[2*N-1:N];
    assign addend = p_q[0] ? m_q : '0;

    full_adder_nbit #(
        .N (N)
    ) u_adder (
        .a_i        (acc),
        .b_i        (addend),
        .cin_i      (1'b0),
        .sum_o      (sum),
        .cout_o     (cout),
        .overflow_o (adder_ovf_unused)
    );

    // With a zero addend the adder passes ACC through with cout=0, so the
    // adder output is always the post-add {C, ACC}. The carry is shifted
    // straight into the product MSB, so no separate carry register is kept.
    assign p_step = {cout, sum, p_q[N-1:1]};

`ifdef EARLY_TERM_EN
    logic [N-1:0]     low_mask;
    logic             rest_zero;
    logic [2*N-1:0]   p_skip;

    // Mask of the cnt multiplier bits not yet consumed (P[cnt-1:0]).
    always_comb begin
        low_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            low_mask[i] = (CW'(i) < cnt_q);
        end
    end

    assign rest_zero = ((p_q[N-1:0] & low_mask) == '0);
    assign p_skip    = p_q >> cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    m_d     = a;
                    p_d     = {{N{1'b0}}, b};
                    cnt_d   = CW'(N);
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef EARLY_TERM_EN
                if (rest_zero) begin
                    p_d     = p_skip;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    p_d   = p_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
`else
                p_d   = p_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign product     = p_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult_ctrl
//   Directed testbench for shift_add_mult_ctrl (N = 4). Expected products and
//   latencies are computed by the bench. Honours EARLY_TERM_EN for latency.
// -----------------------------------------------------------------------------

module tb_shift_add_mult_ctrl;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic           start_valid;
    logic           start_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           done_valid;
    logic           done_ready;
    logic [2*N-1:0] product;
    logic           busy;

    int vectors = 0;
    int errs    = 0;
    int hs_cnt  = 0;

    shift_add_mult_ctrl #(
        .N (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .product     (product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Product handoffs seen on the output handshake.
    always @(posedge clk) begin
        if (rst_n && done_valid && done_ready) hs_cnt++;
    end

    function automatic int exp_lat(input logic [N-1:0] bb);
`ifdef EARLY_TERM_EN
        int msb;
        msb = -1;
        for (int i = 0; i < int'(N); i++) if (bb[i]) msb = i;
        if (msb < 0) return 1;
        if (msb + 2 < int'(N)) return msb + 2;
        return int'(N);
`else
        return int'(N);
`endif
    endfunction

    // Runs one job with done_ready=1, checking latency, product and handoff.
    // Entered and left at #1 after a rising edge, with the DUT in IDLE.
    task automatic run_job(input logic [N-1:0] ta, input logic [N-1:0] tb_v);
        logic [2*N-1:0] expv;
        int el;
        int lat;
        expv = (2*N)'(ta) * (2*N)'(tb_v);
        el   = exp_lat(tb_v);
        vectors++;
        if (start_ready !== 1'b1) begin
            errs++; $display("FAIL job_ready_in: got %b want 1", start_ready);
        end
        a = ta; b = tb_v; start_valid = 1'b1; done_ready = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0; a = N'($urandom); b = N'($urandom);
        lat = 1;
        while (!done_valid && lat < 20) begin
            @(posedge clk); #1;
            if (!done_valid) lat++;
        end
        vectors++;
        if (!done_valid) begin
            errs++; $display("FAIL job_timeout %0dx%0d: done_valid got %b want 1", ta, tb_v, done_valid);
        end else if (lat != el) begin
            errs++; $display("FAIL job_latency %0dx%0d: got %0d want %0d", ta, tb_v, lat, el);
        end
        vectors++;
        if (product !== expv) begin
            errs++; $display("FAIL job_product %0dx%0d: got %0d want %0d", ta, tb_v, product, expv);
        end
        @(posedge clk); #1;
        vectors++;
        if (done_valid !== 1'b0 || start_ready !== 1'b1 || product !== expv) begin
            errs++;
            $display("FAIL job_handoff %0dx%0d: dv=%b sr=%b prod=%0d want dv=0 sr=1 prod=%0d",
                     ta, tb_v, done_valid, start_ready, product, expv);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = N'($urandom); b = N'($urandom);
        start_valid = 1'($urandom); done_ready = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (start_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
            errs++;
            $display("FAIL reset_state: sr=%b dv=%b busy=%b prod=%0d want 1 0 0 0",
                     start_ready, done_valid, busy, product);
        end
        start_valid = 1'b0; done_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || product !== '0) begin
            errs++;
            $display("FAIL reset_release: sr=%b busy=%b prod=%0d want 1 0 0", start_ready, busy, product);
        end
    endtask

    task automatic test_max();
        run_job(4'd15, 4'd15);
    endtask

    task automatic test_backpressure();
        int hs0;
        int w;
        hs0 = hs_cnt;
        a = 4'd7; b = 4'd3; start_valid = 1'b1; done_ready = 1'b0;
        @(posedge clk); #1;
        a = 4'd1; b = 4'd1;                       // start_valid stays high
        w = 0;
        while (!done_valid && w < 20) begin
            @(posedge clk); #1; w++;
        end
        vectors++;
        if (!done_valid || product !== 8'd21) begin
            errs++; $display("FAIL bp_done: dv=%b prod=%0d want 1 21", done_valid, product);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (done_valid !== 1'b1 || product !== 8'd21 || start_ready !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold%0d: dv=%b prod=%0d sr=%b want 1 21 0",
                         k, done_valid, product, start_ready);
            end
        end
        done_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (done_valid !== 1'b0 || start_ready !== 1'b1 || product !== 8'd21 || busy !== 1'b0) begin
            errs++;
            $display("FAIL bp_handoff: dv=%b sr=%b prod=%0d busy=%b want 0 1 21 0",
                     done_valid, start_ready, product, busy);
        end
        start_valid = 1'b0;
        vectors++;
        if (hs_cnt - hs0 != 1) begin
            errs++; $display("FAIL bp_handshakes: got %0d want 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_back_to_back();
        int hs0;
        hs0 = hs_cnt;
        run_job(4'd2, 4'd5);
        run_job(4'd9, 4'd0);
        run_job(4'd0, 4'd12);
        vectors++;
        if (hs_cnt - hs0 != 3) begin
            errs++; $display("FAIL b2b_handshakes: got %0d want 3", hs_cnt - hs0);
        end
    endtask

    task automatic test_reset_mid();
        int hs0;
        hs0 = hs_cnt;
        a = 4'd6; b = 4'd6; start_valid = 1'b1; done_ready = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 || product !== '0) begin
            errs++;
            $display("FAIL midrst_abort: sr=%b busy=%b dv=%b prod=%0d want 1 0 0 0",
                     start_ready, busy, done_valid, product);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (hs_cnt != hs0 || done_valid !== 1'b0 || start_ready !== 1'b1) begin
            errs++;
            $display("FAIL midrst_no_done: hs=%0d dv=%b sr=%b want %0d 0 1",
                     hs_cnt, done_valid, start_ready, hs0);
        end
        run_job(4'd6, 4'd6);
    endtask

    task automatic test_early_term();
        run_job(4'd9, 4'd1);
        run_job(4'd5, 4'd0);
        run_job(4'd7, 4'd3);
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0; a = '0; b = '0;
        test_reset();
        test_max();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_early_term();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
